alu_iter: RTL

Parametrised, multi-cycle ALU that replaces the single-cycle combinational ALU in the datapath. It adds a registered start/done handshake, a full-width iterative multiplier (double-width product) and an iterative divider (quotient and remainder), plus an arithmetic right shift. The controller issues one operation at a time and waits for `done` before writing `result` to ACC. Flags keep the existing `{ZF, CF, OF, SF}` packing.

---
 rtl/alu_iter_if.sv | 31 +++
 rtl/alu_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// Operand/result bundle between the datapath controller and the iterative ALU.
// No latency of its own; it only carries signals.
// Backpressure: the controller may assert start only while busy is low. A start seen while busy is dropped.
interface alu_iter_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] br_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             busy;
    logic             done;
    logic             err;

    // Controller side: issues operations and consumes results.
    modport master (
        output start, op, acc_in, br_in, shamt,
        input  result, result_hi, flags, busy, done, err
    );

    // ALU side.
    modport slave (
        input  start, op, acc_in, br_in, shamt,
        output result, result_hi, flags, busy, done, err
    );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle ALU. It provides a start/done handshake, shift-add MUL and restoring DIV (ALU_ITER_MULDIV_EN).
// Latency: single-cycle ops finish with done in the next cycle. MUL and DIV finish after WIDTH+1 cycles.
// Backpressure: start is accepted only in IDLE (busy low). A start seen while busy is dropped and not queued.
module alu_iter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_iter_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_CLR = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;

`ifdef ALU_ITER_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
`else
    typedef enum logic [1:0] {IDLE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] a, b;
    assign a = bus.acc_in;
    assign b = bus.br_in;

    // One spare bit catches the carry/borrow and the last bit shifted out.
    logic [WIDTH:0]        add_t, sub_t, shl_t, shr_t;
    logic signed [WIDTH:0] sar_t;
    assign add_t = {1'b0, a} + {1'b0, b};
    assign sub_t = {1'b0, a} - {1'b0, b};
    assign shl_t = {1'b0, a} << bus.shamt;
    assign shr_t = {a, 1'b0} >> bus.shamt;
    assign sar_t = $signed({a, 1'b0}) >>> bus.shamt;

    logic [WIDTH-1:0] sc_res, sc_hi;
    logic [3:0]       sc_flags;
    logic             sc_cf, sc_of, sc_err, sc_div0;

    // Result of every op that completes in the accepting cycle.
    always_comb begin
        sc_res  = a;
        sc_hi   = '0;
        sc_cf   = 1'b0;
        sc_of   = 1'b0;
        sc_err  = 1'b0;
        sc_div0 = 1'b0;
        case (bus.op)
            OP_CLR: sc_res = '0;
            OP_ADD: begin
                sc_res = add_t[MSB:0];
                sc_cf  = add_t[WIDTH];
                sc_of  = (a[MSB] == b[MSB]) && (add_t[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_res = sub_t[MSB:0];
                sc_cf  = sub_t[WIDTH];
                sc_of  = (a[MSB] != b[MSB]) && (sub_t[MSB] != a[MSB]);
            end
            OP_SHL: begin
                sc_res = shl_t[MSB:0];
                sc_cf  = shl_t[WIDTH];
            end
            OP_SHR: begin
                sc_res = shr_t[WIDTH:1];
                sc_cf  = shr_t[0];
            end
            OP_SAR: begin
                sc_res = sar_t[WIDTH:1];
                sc_cf  = sar_t[0];
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_NOT: sc_res = ~b;
`ifdef ALU_ITER_MULDIV_EN
            OP_MUL: ;
            OP_DIV: begin
                // Only a zero divisor reaches this path. Non-zero divisors iterate.
                sc_res  = '1;
                sc_hi   = a;
                sc_div0 = 1'b1;
            end
`endif
            default: sc_err = 1'b1;
        endcase
        sc_flags = sc_div0 ? 4'b0100 : {(sc_res == '0), sc_cf, sc_of, sc_res[MSB]};
    end

`ifdef ALU_ITER_MULDIV_EN
    // hi holds the partial product or remainder. lo holds the multiplier or the dividend becoming the quotient.
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic             div_ge;

    // One shift-add step and one restoring-division step per cycle.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[MSB:1]};
        div_sh   = {hi_q, lo_q[MSB]};
        div_diff = div_sh - {1'b0, dvs_q};
        div_ge   = !div_diff[WIDTH];
        div_hi_n = div_ge ? div_diff[MSB:0] : div_sh[MSB:0];
        div_lo_n = {lo_q[MSB-1:0], div_ge};
    end
`endif

    // Next-state logic: accept in IDLE, iterate in the RUN states, publish on the last step.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
`ifdef ALU_ITER_MULDIV_EN
        hi_d  = hi_q;
        lo_d  = lo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef ALU_ITER_MULDIV_EN
                    if (bus.op == OP_MUL || (bus.op == OP_DIV && b != '0)) begin
                        state_d = (bus.op == OP_MUL) ? MUL_RUN : DIV_RUN;
                        busy_d  = 1'b1;
                        hi_d    = '0;
                        lo_d    = a;
                        dvs_d   = b;
                        cnt_d   = '0;
                    end else
`endif
                    begin
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        flags_d     = sc_flags;
                        err_d       = sc_err;
                        done_d      = 1'b1;
                    end
                end
            end
`ifdef ALU_ITER_MULDIV_EN
            MUL_RUN: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b0;
                    result_d    = mul_lo_n;
                    result_hi_d = mul_hi_n;
                    flags_d     = {({mul_hi_n, mul_lo_n} == '0), (mul_hi_n != '0),
                                   (mul_hi_n != '0), mul_lo_n[MSB]};
                end
            end
            DIV_RUN: begin
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b0;
                    result_d    = div_lo_n;
                    result_hi_d = div_hi_n;
                    flags_d     = {(div_lo_n == '0), 1'b0, 1'b0, div_lo_n[MSB]};
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset aborts any running op and wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
            hi_q  <= '0;
            lo_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef ALU_ITER_MULDIV_EN
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
`endif
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
